// File: rtl/chroma_pkg.sv
// Shared definitions for the chroma compositor pixel paths: pixel width,
// RGB565 field positions, FSM encoding and the RGB565 -> RGB10 expansion.
package chroma_pkg;

    localparam int PIX_W = 10;

    localparam int R_MSB = 15;
    localparam int R_LSB = 11;
    localparam int G_MSB = 10;
    localparam int G_LSB = 5;
    localparam int B_MSB = 4;
    localparam int B_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } bg_state_t;

    typedef struct packed {
        logic [PIX_W-1:0] r;
        logic [PIX_W-1:0] g;
        logic [PIX_W-1:0] b;
    } rgb10_t;

    localparam rgb10_t RGB10_BLACK = '{r: 10'h000, g: 10'h000, b: 10'h000};

    // Bit replication keeps full-scale codes at full scale (5'h1F -> 10'h3FF).
    function automatic rgb10_t rgb565_to_rgb10(input logic [15:0] word);
        rgb10_t pix;
        pix.r = {word[R_MSB:R_LSB], word[R_MSB:R_LSB]};
        pix.g = {word[G_MSB:G_LSB], word[G_MSB:G_MSB-3]};
        pix.b = {word[B_MSB:B_LSB], word[B_MSB:B_LSB]};
        return pix;
    endfunction

endpackage

// File: rtl/bg_fifo.sv
// Synchronous prefetch FIFO with flush; head word is visible combinationally.
module bg_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;
    assign empty = (count_r == (AW+1)'(0));
    assign full  = (count_r == (AW+1)'(DEPTH));

endmodule

// File: rtl/bg_fifo_chk.sv
// Protocol checker for the prefetch FIFO: the read credit scheme must never push into a full FIFO.
module bg_fifo_chk (
    input logic clk,
    input logic rst_n,
    input logic push,
    input logic full
);
    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && full))
        else $error("bg_fifo push while full");
endmodule

// File: rtl/bg_image_fetch.sv
// Background image prefetcher: credit-limited reads from frame memory, stale-return
// dropping across frame aborts, and a registered RGB10 pixel per display request.
module bg_image_fetch
    import chroma_pkg::*;
#(
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 19
) (
    input  logic              iCLK27,
    input  logic              iRST_N,
    input  logic              iImageEnable,
    input  logic              iFrameStart,
    input  logic              iPixReq,
    output logic [ADDR_W-1:0] oMemAddr,
    output logic              oMemRd,
    input  logic              iMemWait,
    input  logic              iMemRdValid,
    input  logic [15:0]       iMemData,
    output logic [PIX_W-1:0]  oRed,
    output logic [PIX_W-1:0]  oGreen,
    output logic [PIX_W-1:0]  oBlue,
    output logic              oUnderflow
);
    localparam int                CW     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] TOTAL  = ADDR_W'(IMG_W * IMG_H);
    localparam logic [CW:0]       CREDIT = (CW+1)'(FIFO_DEPTH);

    bg_state_t         state_r, state_s;
    logic [ADDR_W-1:0] addr_r, addr_s;
    logic [CW-1:0]     outst_r, outst_s;
    logic [CW-1:0]     drop_r, drop_s;
    logic [CW-1:0]     count_s, count_next_s;
    logic [CW:0]       credit_used_s;
    logic              rd_r, rd_s;
    logic              uf_r, uf_s;
    rgb10_t            pix_r, pix_s;

    logic              fs_s, accept_s, flush_s, active_s;
    logic              push_s, pop_req_s, pop_s;
    logic              empty_s, full_s;
    logic [15:0]       head_s;

    assign fs_s      = iImageEnable && iFrameStart;
    assign accept_s  = rd_r && !iMemWait;
    assign flush_s   = !iImageEnable || fs_s;
    assign active_s  = (state_r != ST_IDLE);
    assign push_s    = iMemRdValid && active_s && !flush_s && (drop_r == CW'(0));
    assign pop_req_s = iPixReq && active_s && !flush_s;
    assign pop_s     = pop_req_s && !empty_s;

    bg_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk       (iCLK27),
        .rst_n     (iRST_N),
        .flush     (flush_s),
        .push      (push_s),
        .push_data (iMemData),
        .pop       (pop_s),
        .head      (head_s),
        .count     (count_s),
        .empty     (empty_s),
        .full      (full_s)
    );

    // Next state, address, credit and drop accounting, and the next read request.
    always_comb begin
        state_s      = state_r;
        addr_s       = addr_r;
        outst_s      = outst_r;
        drop_s       = drop_r;
        count_next_s = count_s;

        if (!iImageEnable) begin
            state_s = ST_IDLE;
        end else if (iFrameStart) begin
            state_s = ST_RUN;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (accept_s && (addr_r == TOTAL - ADDR_W'(1))) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_RUN;
                    end
                end
                ST_DONE: state_s = ST_DONE;
                default: state_s = ST_IDLE;
            endcase
        end

        if (flush_s) begin
            addr_s = {ADDR_W{1'b0}};
        end else if (accept_s) begin
            addr_s = addr_r + ADDR_W'(1);
        end else begin
            addr_s = addr_r;
        end

        case ({accept_s, iMemRdValid})
            2'b10:   outst_s = outst_r + CW'(1);
            2'b01:   outst_s = outst_r - CW'(1);
            default: outst_s = outst_r;
        endcase

        // Everything still in flight at a flush belongs to the abandoned frame.
        if (flush_s) begin
            drop_s = outst_s;
        end else if (iMemRdValid && (drop_r != CW'(0))) begin
            drop_s = drop_r - CW'(1);
        end else begin
            drop_s = drop_r;
        end

        if (flush_s) begin
            count_next_s = CW'(0);
        end else begin
            case ({push_s && !full_s, pop_s})
                2'b10:   count_next_s = count_s + CW'(1);
                2'b01:   count_next_s = count_s - CW'(1);
                default: count_next_s = count_s;
            endcase
        end

        credit_used_s = {1'b0, count_next_s} + {1'b0, outst_s};
        rd_s = (state_s == ST_RUN) && (credit_used_s < CREDIT) && (addr_s < TOTAL);
    end

    // Output pixel and underflow flag; a frame start overrides a same-cycle request.
    always_comb begin
        pix_s = pix_r;
        uf_s  = uf_r;
        if (fs_s) begin
            uf_s = 1'b0;
        end else if (pop_req_s) begin
            if (!empty_s) begin
                pix_s = rgb565_to_rgb10(head_s);
            end else begin
                pix_s = RGB10_BLACK;
                uf_s  = 1'b1;
            end
        end else if (iPixReq) begin
            pix_s = RGB10_BLACK;
        end else begin
            pix_s = pix_r;
        end
    end

    // State and output registers.
    always_ff @(posedge iCLK27 or negedge iRST_N) begin
        if (!iRST_N) begin
            state_r <= ST_IDLE;
            addr_r  <= {ADDR_W{1'b0}};
            outst_r <= {CW{1'b0}};
            drop_r  <= {CW{1'b0}};
            rd_r    <= 1'b0;
            uf_r    <= 1'b0;
            pix_r   <= RGB10_BLACK;
        end else begin
            state_r <= state_s;
            addr_r  <= addr_s;
            outst_r <= outst_s;
            drop_r  <= drop_s;
            rd_r    <= rd_s;
            uf_r    <= uf_s;
            pix_r   <= pix_s;
        end
    end

    assign oMemAddr   = addr_r;
    assign oMemRd     = rd_r;
    assign oRed       = pix_r.r;
    assign oGreen     = pix_r.g;
    assign oBlue      = pix_r.b;
    assign oUnderflow = uf_r;

endmodule

// File: tb/tb_bg_image_fetch.sv
// Self-checking bench for bg_image_fetch on a small 8x4 image with a latency-programmable memory model.
module tb_bg_image_fetch;
    localparam int W   = 8;
    localparam int H   = 4;
    localparam int TOT = W * H;
    localparam int D   = 16;
    localparam int AW  = 19;

    logic          iCLK27 = 1'b0;
    logic          iRST_N;
    logic          iImageEnable, iFrameStart, iPixReq, iMemWait;
    logic          iMemRdValid;
    logic [15:0]   iMemData;
    logic [AW-1:0] oMemAddr;
    logic          oMemRd;
    logic [9:0]    oRed, oGreen, oBlue;
    logic          oUnderflow;

    bg_image_fetch #(.IMG_W(W), .IMG_H(H), .FIFO_DEPTH(D), .ADDR_W(AW)) dut (
        .iCLK27(iCLK27), .iRST_N(iRST_N), .iImageEnable(iImageEnable), .iFrameStart(iFrameStart),
        .iPixReq(iPixReq), .oMemAddr(oMemAddr), .oMemRd(oMemRd), .iMemWait(iMemWait),
        .iMemRdValid(iMemRdValid), .iMemData(iMemData), .oRed(oRed), .oGreen(oGreen),
        .oBlue(oBlue), .oUnderflow(oUnderflow)
    );

    bg_fifo_chk u_chk (.clk(iCLK27), .rst_n(iRST_N), .push(dut.u_fifo.push), .full(dut.u_fifo.full));

    always #5 iCLK27 = ~iCLK27;

    typedef struct { logic [15:0] data; int due; int tag; } req_t;
    req_t        pend[$];
    logic [15:0] mq[$];
    logic [15:0] mem_img [TOT];
    int          cyc, lat, epoch, ret_tag, next_addr, acc_cnt, addr_err, max_occ;
    bit          active;
    logic [29:0] exp_rgb;
    logic        exp_uf;
    int          pass_cnt, total_cnt;

    function automatic logic [29:0] ref_pix(input logic [15:0] w);
        int r, g, b;
        r = int'(w[15:11]);
        g = int'(w[10:5]);
        b = int'(w[4:0]);
        return {10'(r * 33), 10'(g * 16 + g / 4), 10'(b * 33)};
    endfunction

    // Memory responder plus frame-level reference model of the pixel stream.
    initial begin
        req_t p;
        int   occ, e0;
        bit   acc;
        iMemRdValid = 1'b0; iMemData = 16'h0;
        forever begin
            @(posedge iCLK27); #1;
            cyc++;
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                p = pend.pop_front();
                iMemRdValid = 1'b1; iMemData = p.data; ret_tag = p.tag;
            end else begin
                iMemRdValid = 1'b0; iMemData = 16'h0;
            end
            @(negedge iCLK27);
            if (iRST_N) begin
                occ = pend.size() + mq.size() + (iMemRdValid ? 1 : 0);
                if (occ > max_occ) max_occ = occ;
                e0  = epoch;
                acc = oMemRd && !iMemWait;
                if (acc) begin
                    if (!active || int'(oMemAddr) != next_addr) addr_err++;
                    next_addr++; acc_cnt++;
                end
                if (!iImageEnable) begin
                    active = 1'b0; mq.delete(); epoch++;
                    if (iPixReq) exp_rgb = 30'h0;
                end else if (iFrameStart) begin
                    active = 1'b1; mq.delete(); epoch++;
                    exp_uf = 1'b0; next_addr = 0; acc_cnt = 0;
                end else if (active) begin
                    if (iPixReq) begin
                        if (mq.size() > 0) exp_rgb = ref_pix(mq.pop_front());
                        else begin exp_rgb = 30'h0; exp_uf = 1'b1; end
                    end
                    if (iMemRdValid && ret_tag == epoch) mq.push_back(iMemData);
                end else if (iPixReq) begin
                    exp_rgb = 30'h0;
                end
                if (acc) pend.push_back('{data: mem_img[int'(oMemAddr) % TOT], due: cyc + lat, tag: e0});
            end
        end
    end

    task automatic step();
        @(posedge iCLK27); #2;
    endtask

    task automatic frame_start();
        iFrameStart = 1'b1; step(); iFrameStart = 1'b0;
    endtask

    task automatic test_reset();
        total_cnt += 6;
        if (oRed !== 10'h0)     $display("FAIL reset_red: got %h, expected 0", oRed);     else pass_cnt++;
        if (oGreen !== 10'h0)   $display("FAIL reset_green: got %h, expected 0", oGreen); else pass_cnt++;
        if (oBlue !== 10'h0)    $display("FAIL reset_blue: got %h, expected 0", oBlue);   else pass_cnt++;
        if (oUnderflow !== 1'b0) $display("FAIL reset_uf: got %b, expected 0", oUnderflow); else pass_cnt++;
        if (oMemRd !== 1'b0)    $display("FAIL reset_rd: got %b, expected 0", oMemRd);    else pass_cnt++;
        if (oMemAddr !== '0)    $display("FAIL reset_addr: got %h, expected 0", oMemAddr); else pass_cnt++;
    endtask

    task automatic test_stream();
        lat = 1;
        for (int i = 0; i < TOT; i++) mem_img[i] = 16'(i);
        frame_start();
        total_cnt++;
        if (oMemRd !== 1'b1 || oMemAddr !== '0) $display("FAIL stream_first_rd: rd=%b addr=%h, expected 1/0", oMemRd, oMemAddr);
        else pass_cnt++;
        for (int c = 1; c < 70; c++) begin
            iPixReq = (c >= 20 && c < 20 + TOT);
            step();
            total_cnt++;
            if ({oRed, oGreen, oBlue} !== exp_rgb || oUnderflow !== exp_uf)
                $display("FAIL stream cyc %0d: rgb=%h uf=%b, expected rgb=%h uf=%b", c, {oRed, oGreen, oBlue}, oUnderflow, exp_rgb, exp_uf);
            else pass_cnt++;
        end
        total_cnt += 4;
        if (acc_cnt != TOT || addr_err != 0) $display("FAIL stream_reads: reads=%0d addr_err=%0d, expected %0d/0", acc_cnt, addr_err, TOT); else pass_cnt++;
        if (oMemRd !== 1'b0) $display("FAIL stream_done_rd: got %b, expected 0", oMemRd); else pass_cnt++;
        if (oUnderflow !== 1'b0) $display("FAIL stream_uf: got %b, expected 0", oUnderflow); else pass_cnt++;
        if ({oRed, oGreen, oBlue} !== ref_pix(16'(TOT - 1))) $display("FAIL stream_last: got %h, expected %h", {oRed, oGreen, oBlue}, ref_pix(16'(TOT - 1))); else pass_cnt++;
    endtask

    task automatic test_wait();
        lat = 1;
        for (int i = 0; i < TOT; i++) mem_img[i] = 16'($urandom);
        frame_start();
        repeat (3) step();
        iMemWait = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            total_cnt++;
            if (oMemRd !== 1'b1 || int'(oMemAddr) != next_addr)
                $display("FAIL wait_hold cyc %0d: rd=%b addr=%0d, expected 1/%0d", c, oMemRd, oMemAddr, next_addr);
            else pass_cnt++;
        end
        iMemWait = 1'b0;
        iPixReq = 1'b1;
        for (int c = 0; c < 50; c++) begin
            step();
            total_cnt++;
            if ({oRed, oGreen, oBlue} !== exp_rgb || oUnderflow !== exp_uf)
                $display("FAIL wait_pix cyc %0d: rgb=%h uf=%b, expected rgb=%h uf=%b", c, {oRed, oGreen, oBlue}, oUnderflow, exp_rgb, exp_uf);
            else pass_cnt++;
        end
        iPixReq = 1'b0;
        total_cnt++;
        if (acc_cnt != TOT || addr_err != 0) $display("FAIL wait_reads: reads=%0d addr_err=%0d, expected %0d/0", acc_cnt, addr_err, TOT); else pass_cnt++;
    endtask

    task automatic test_latency();
        lat = 8; max_occ = 0;
        for (int i = 0; i < TOT; i++) mem_img[i] = 16'($urandom);
        frame_start();
        for (int c = 0; c < 120; c++) begin
            iPixReq = ($urandom_range(1, 0) == 1);
            step();
            total_cnt++;
            if ({oRed, oGreen, oBlue} !== exp_rgb || oUnderflow !== exp_uf)
                $display("FAIL latency cyc %0d: rgb=%h uf=%b, expected rgb=%h uf=%b", c, {oRed, oGreen, oBlue}, oUnderflow, exp_rgb, exp_uf);
            else pass_cnt++;
        end
        iPixReq = 1'b0;
        total_cnt += 2;
        if (max_occ > D) $display("FAIL latency_credit: max occupancy %0d, limit %0d", max_occ, D); else pass_cnt++;
        if (acc_cnt != TOT || addr_err != 0) $display("FAIL latency_reads: reads=%0d addr_err=%0d, expected %0d/0", acc_cnt, addr_err, TOT); else pass_cnt++;
    endtask

    task automatic test_colors();
        logic [15:0] words [4];
        logic [29:0] want  [4];
        words[0] = 16'hF800; want[0] = {10'h3FF, 10'h000, 10'h000};
        words[1] = 16'h07E0; want[1] = {10'h000, 10'h3FF, 10'h000};
        words[2] = 16'h001F; want[2] = {10'h000, 10'h000, 10'h3FF};
        words[3] = 16'hFFFF; want[3] = {10'h3FF, 10'h3FF, 10'h3FF};
        lat = 1;
        for (int i = 0; i < TOT; i++) mem_img[i] = (i < 4) ? words[i] : 16'h0000;
        frame_start();
        repeat (12) step();
        for (int i = 0; i < 4; i++) begin
            iPixReq = 1'b1; step(); iPixReq = 1'b0;
            total_cnt++;
            if ({oRed, oGreen, oBlue} !== want[i]) $display("FAIL color_%0d: got %h, expected %h", i, {oRed, oGreen, oBlue}, want[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_underflow();
        lat = 1;
        frame_start();
        iPixReq = 1'b1; step(); iPixReq = 1'b0;
        total_cnt += 2;
        if ({oRed, oGreen, oBlue} !== 30'h0) $display("FAIL uf_pixel: got %h, expected 0", {oRed, oGreen, oBlue}); else pass_cnt++;
        if (oUnderflow !== 1'b1) $display("FAIL uf_set: got %b, expected 1", oUnderflow); else pass_cnt++;
        repeat (3) step();
        frame_start();
        total_cnt++;
        if (oUnderflow !== 1'b0) $display("FAIL uf_clear: got %b, expected 0", oUnderflow); else pass_cnt++;
        repeat (20) step();
    endtask

    task automatic test_abort();
        logic [15:0] first_b;
        lat = 8;
        for (int i = 0; i < TOT; i++) mem_img[i] = 16'($urandom);
        frame_start();
        repeat (5) step();
        for (int i = 0; i < TOT; i++) mem_img[i] = ~mem_img[i];
        first_b = mem_img[0];
        iFrameStart = 1'b1; iMemWait = 1'b1; iPixReq = 1'b1;
        step();
        iFrameStart = 1'b0; iMemWait = 1'b0; iPixReq = 1'b0;
        total_cnt++;
        if (oUnderflow !== 1'b0) $display("FAIL abort_fs_pix_uf: got %b, expected 0", oUnderflow); else pass_cnt++;
        for (int c = 0; c < 30; c++) begin
            step();
            total_cnt++;
            if ({oRed, oGreen, oBlue} !== exp_rgb || oUnderflow !== exp_uf)
                $display("FAIL abort cyc %0d: rgb=%h uf=%b, expected rgb=%h uf=%b", c, {oRed, oGreen, oBlue}, oUnderflow, exp_rgb, exp_uf);
            else pass_cnt++;
        end
        iPixReq = 1'b1; step(); iPixReq = 1'b0;
        total_cnt++;
        if ({oRed, oGreen, oBlue} !== ref_pix(first_b)) $display("FAIL abort_first: got %h, expected %h", {oRed, oGreen, oBlue}, ref_pix(first_b));
        else pass_cnt++;
    endtask

    task automatic test_disable();
        lat = 8;
        frame_start();
        repeat (3) step();
        iImageEnable = 1'b0; iPixReq = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            total_cnt += 2;
            if (oMemRd !== 1'b0) $display("FAIL disable_rd cyc %0d: got %b, expected 0", c, oMemRd); else pass_cnt++;
            if ({oRed, oGreen, oBlue} !== 30'h0) $display("FAIL disable_pix cyc %0d: got %h, expected 0", c, {oRed, oGreen, oBlue}); else pass_cnt++;
        end
        iImageEnable = 1'b1; iPixReq = 1'b0;
        step();
        frame_start();
        repeat (25) step();
        iPixReq = 1'b1; step(); iPixReq = 1'b0;
        total_cnt++;
        if ({oRed, oGreen, oBlue} !== ref_pix(mem_img[0]) || oUnderflow !== 1'b0)
            $display("FAIL disable_restart: rgb=%h uf=%b, expected rgb=%h uf=0", {oRed, oGreen, oBlue}, oUnderflow, ref_pix(mem_img[0]));
        else pass_cnt++;
    endtask

    initial begin
        iRST_N = 1'b0; iImageEnable = 1'b0; iFrameStart = 1'b0; iPixReq = 1'b0; iMemWait = 1'b0;
        lat = 1; exp_rgb = 30'h0; exp_uf = 1'b0; active = 1'b0;
        for (int i = 0; i < TOT; i++) mem_img[i] = 16'h0;
        repeat (3) @(posedge iCLK27);
        #2 iRST_N = 1'b1;
        step();
        test_reset();
        iImageEnable = 1'b1;
        step();
        test_stream();
        test_wait();
        test_latency();
        test_colors();
        test_underflow();
        test_abort();
        test_disable();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/bg_image_fetch.md
# bg_image_fetch

Upstream feeder for the chroma compositor: prefetches the stored background image from frame memory as 16-bit RGB565 words, buffers them in a small FIFO, and delivers one expanded 10-bit R/G/B pixel per display pixel request. Its outputs drive the compositor's background-pixel inputs (imVGA_R/G/B) in lock-step with the VGA controller's pixel requests. It sits between the SRAM read port and the chroma compositor in the iCLK27 domain.

## Interface
- IMG_W, 640, background width in pixels
- IMG_H, 480, background height in lines
- FIFO_DEPTH, 16, prefetch FIFO entries (power of two, ≥4)
- ADDR_W, 19, word address width (≥ clog2(IMG_W*IMG_H))

Ports. One clock; reset is asynchronous and active-low.
- iCLK27  in  1  pixel clock
- iRST_N  in  1  asynchronous active-low reset
- iImageEnable  in  1  background enabled; low = idle and flushed
- iFrameStart  in  1  one-cycle pulse at start of each frame (before first iPixReq)
- iPixReq  in  1  display consumes one background pixel this cycle
- oMemAddr  out  ADDR_W  read word address
- oMemRd  out  1  read request
- iMemWait  in  1  memory stall; request accepted when oMemRd && !iMemWait
- iMemRdValid  in  1  read data valid, returns in request order, any latency ≥1
- iMemData  in  16  RGB565 word {R5,G6,B5}
- oRed, oGreen, oBlue  out  10 each  expanded background pixel
- oUnderflow  out  1  sticky: a request found the FIFO empty this frame

## Operation
- States: IDLE, RUN, DONE.
- IDLE: no reads. Entered at reset, or when iImageEnable is low (any state, takes priority). iFrameStart with iImageEnable high → RUN.
- RUN, at iFrameStart entry: FIFO flushed, address = 0, oUnderflow cleared, drop counter = current outstanding reads.
- Read issue rule: assert oMemRd when fifo_count + outstanding < FIFO_DEPTH and address < IMG_W*IMG_H. Address increments on acceptance only; oMemRd/oMemAddr hold stable while iMemWait is high.
- When address reaches IMG_W*IMG_H, enter DONE. DONE issues no reads and keeps serving pops. iFrameStart → RUN with a fresh frame.
- Returns: while the drop counter is nonzero, iMemRdValid decrements it and the data is discarded (stale data from the aborted frame). Otherwise the word is pushed to the FIFO. Outstanding decrements on every return.
- The credit rule makes overflow impossible. An assertion flags any push when full.
- Pop: iPixReq with FIFO non-empty pops the head and registers the expanded pixel.
- Underflow: iPixReq with FIFO empty outputs 0/0/0 and sets oUnderflow.
- iPixReq in IDLE: outputs 0, no flag.
- Expansion by bit replication:
  - R10 = {R5,R5}
  - G10 = {G6,G6[5:2]}
  - B10 = {B5,B5}
- Example: 16'hFFFF → 10'h3FF on all three channels; 16'h0000 → 0.

## Timing
- Reset: all outputs 0; state IDLE; FIFO empty; counters 0.
- Pixel latency: oRed/oGreen/oBlue update on the edge after iPixReq and hold until the next pop.
- Memory: first oMemRd is asserted in the cycle after iFrameStart.
- Simultaneous events:
  - iFrameStart with iPixReq: frame start wins; the pop is ignored and no underflow is flagged.
  - iFrameStart with iMemRdValid: the return counts against the new drop counter.
  - Push and pop in the same cycle on a non-empty FIFO: count unchanged. On an empty FIFO the pop underflows and the push still lands.
  - iImageEnable falling mid-frame: go to IDLE and flush. Outstanding returns are dropped via the drop counter.
- Throughput: sustains one pixel per cycle with zero-wait memory and return latency < FIFO_DEPTH.

## Structure
- Shared package chroma_pkg holds:
  - PIX_W = 10
  - RGB565 field positions
  - the rgb565_to_rgb10 expansion function, reused by any other memory-sourced pixel path
- One sub-module: bg_fifo, a synchronous FIFO (DEPTH, WIDTH = 16) with flush, push, pop, count, empty and full.
- The FSM, credit/drop counters and output register live in bg_image_fetch.

## Test plan
- Reset then iFrameStart, zero-wait memory returning address as data, with iPixReq continuous from cycle 20. Expected: outputs follow the address sequence, oUnderflow stays 0, and exactly IMG_W*IMG_H reads are issued before DONE.
- iMemWait high for 10 cycles mid-frame. Expected: oMemAddr and oMemRd stay constant and no address is skipped.
- Memory latency 8, FIFO_DEPTH 16. Expected: outstanding + fifo_count never exceeds 16 and no push occurs when full.
- Read data 16'hF800. Expected: 10'h3FF / 0 / 0. Read data 16'h07E0. Expected: 0 / 10'h3FF / 0.
- iPixReq at cycle 1 after iFrameStart (FIFO empty). Expected: output 0/0/0 and oUnderflow = 1. oUnderflow clears on the next iFrameStart.
- iFrameStart with 5 reads outstanding. Expected: those 5 returns are discarded and the first popped pixel is the word from address 0.
